// File: rtl/layer1_counter_func0.sv
// ============================================================================
// Module   : layer1_counter_func0
// Brief    : Layer-1 MAC completion counter with sticky done flag, plus a
//            combinational Q4.4 sigmoid lookup (func0).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module layer1_counter_func0 #(
    parameter int N_INPUTS = 2,
    parameter int DW       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ack,
    output logic                 ack_mac,
    input  logic signed [DW-1:0] z_value,
    output logic signed [DW-1:0] a
);

    localparam int             CW    = $clog2(N_INPUTS + 1);
    localparam logic [CW-1:0]  c_N   = CW'(N_INPUTS);
    localparam int             c_LUT = 2 ** DW;

    // Smallest z (Q4.4 integer) whose rounded sigmoid reaches 1..16:
    // z >= 16*ln((2k-1)/(33-2k)), so a is simply the count of thresholds met.
    localparam int c_THR [16] = '{-54, -36, -26, -20, -15, -10, -6, -2,
                                    3,   7,  11,  16,  21,  27,  37, 55};

    // ------------------------------------------------------------------
    // Counter: saturating MAC completion count and sticky done flag
    // ------------------------------------------------------------------
    logic [CW-1:0] r_count;
    logic          r_ack_mac;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_ack_mac <= 1'b0;
        end else if (ack && (r_count < c_N)) begin
            r_count <= r_count + 1'b1;
            if (r_count == c_N - 1'b1) begin
                r_ack_mac <= 1'b1;
            end
        end
    end

    assign ack_mac = r_ack_mac;

    // ------------------------------------------------------------------
    // func0: constant 2**DW-entry sigmoid table indexed by z_value
    // ------------------------------------------------------------------
    function automatic logic [4:0] f_sigmoid(input int idx);
        int z;
        int cnt;
        z   = idx - (2 ** (DW - 1));
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (z >= c_THR[k]) begin
                cnt = cnt + 1;
            end
        end
        return 5'(cnt);
    endfunction

    logic [4:0]    w_lut [c_LUT];
    logic [DW-1:0] w_idx;

    generate
        for (genvar g = 0; g < c_LUT; g++) begin : g_lut
            assign w_lut[g] = f_sigmoid(g);
        end
    endgenerate

    // Offset-binary index: -2**(DW-1) maps to entry 0
    assign w_idx = {~z_value[DW-1], z_value[DW-2:0]};
    assign a     = {{(DW-5){1'b0}}, w_lut[w_idx]};

endmodule

`default_nettype wire

// File: tb/tb_layer1_counter_func0.sv
// Self-checking bench for layer1_counter_func0: counter scenarios, randomized
// ack/rst traffic against a pulse-count model, and a full sigmoid sweep.
`default_nettype none

module tb_layer1_counter_func0;

    localparam int N_INPUTS = 2;
    localparam int DW       = 8;

    logic                 clk;
    logic                 rst;
    logic                 ack;
    logic                 ack_mac;
    logic signed [DW-1:0] z_value;
    logic signed [DW-1:0] a;

    int checks;
    int errors;
    int pulses;   // accepted ack pulses since last reset (model)

    layer1_counter_func0 #(
        .N_INPUTS (N_INPUTS),
        .DW       (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ack     (ack),
        .ack_mac (ack_mac),
        .z_value (z_value),
        .a       (a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the current inputs; update model; settle at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst) pulses = 0;
        else if (ack) pulses = pulses + 1;
        @(negedge clk);
    endtask

    function automatic logic exp_done();
        return (pulses >= N_INPUTS);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ack = i[0] ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (ack_mac !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d ack_mac=%b expected=0", i, ack_mac);
            end
        end
        rst = 1'b0;
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ack_mac !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d ack_mac=%b expected=0", i, ack_mac);
            end
        end
    endtask

    task automatic test_count();
        logic exp;
        rst = 1'b1; ack = 1'b0; tick(); rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            ack = (c == 3 || c == 6 || c == 9 || c == 10);
            tick();
            exp = (c >= 6);
            checks++;
            if (ack_mac !== exp || ack_mac !== exp_done()) begin
                errors++;
                $display("FAIL count cyc%0d ack_mac=%b expected=%b", c, ack_mac, exp);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        rst = 1'b1; ack = 1'b0; tick(); rst = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0; tick();
        checks++;
        if (ack_mac !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_one ack_mac=%b expected=0", ack_mac);
        end
        ack = 1'b1; tick(); ack = 1'b0; tick();
        checks++;
        if (ack_mac !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_two ack_mac=%b expected=1", ack_mac);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1; ack = 1'b0; tick(); rst = 1'b0;
        ack = 1'b1; tick();
        rst = 1'b1; ack = 1'b1; tick();
        rst = 1'b0; ack = 1'b0;
        checks++;
        if (ack_mac !== 1'b0) begin
            errors++;
            $display("FAIL simul_rst ack_mac=%b expected=0", ack_mac);
        end
        // Count must be back at zero: a single pulse is not enough.
        ack = 1'b1; tick(); ack = 1'b0; tick();
        checks++;
        if (ack_mac !== 1'b0) begin
            errors++;
            $display("FAIL simul_count_zero ack_mac=%b expected=0", ack_mac);
        end
    endtask

    task automatic test_continuous();
        rst = 1'b1; ack = 1'b0; tick(); rst = 1'b0;
        ack = 1'b1; tick();
        checks++;
        if (ack_mac !== 1'b0) begin
            errors++;
            $display("FAIL cont_first ack_mac=%b expected=0", ack_mac);
        end
        tick();
        checks++;
        if (ack_mac !== 1'b1) begin
            errors++;
            $display("FAIL cont_second ack_mac=%b expected=1", ack_mac);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (ack_mac !== 1'b1) begin
            errors++;
            $display("FAIL cont_sticky ack_mac=%b expected=1", ack_mac);
        end
        ack = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ack = ($urandom_range(0, 99) < 40);
            rst = ($urandom_range(0, 99) < 8);
            tick();
            checks++;
            if (ack_mac !== exp_done()) begin
                errors++;
                $display("FAIL random cyc%0d ack_mac=%b expected=%b pulses=%0d",
                         i, ack_mac, exp_done(), pulses);
            end
        end
        rst = 1'b0; ack = 1'b0;
    endtask

    function automatic int ref_sigmoid(input int z);
        real v;
        v = 16.0 / (1.0 + $exp(-(real'(z)) / 16.0));
        return int'($floor(v + 0.5));
    endfunction

    task automatic test_func0_sweep();
        int prev;
        int av;
        int anc_z [5] = '{-128, -13, 0, 16, 127};
        int anc_a [5] = '{0, 5, 8, 12, 16};
        prev = 0;
        for (int z = -128; z <= 127; z++) begin
            z_value = DW'(z);
            #1;
            av = int'(a);
            checks++;
            if (av !== ref_sigmoid(z)) begin
                errors++;
                $display("FAIL func0_formula z=%0d a=%0d expected=%0d", z, av, ref_sigmoid(z));
            end
            checks++;
            if (av < 0 || av > 16 || av < prev) begin
                errors++;
                $display("FAIL func0_range_mono z=%0d a=%0d prev=%0d", z, av, prev);
            end
            prev = av;
        end
        for (int i = 0; i < 5; i++) begin
            z_value = DW'(anc_z[i]);
            #1;
            checks++;
            if (int'(a) !== anc_a[i]) begin
                errors++;
                $display("FAIL func0_anchor z=%0d a=%0d expected=%0d", anc_z[i], int'(a), anc_a[i]);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        pulses  = 0;
        rst     = 1'b1;
        ack     = 1'b0;
        z_value = '0;
        @(negedge clk);
        test_reset();
        test_count();
        test_mid_reset();
        test_simultaneous();
        test_continuous();
        test_random();
        test_func0_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/layer1_counter_func0.md
# layer1_counter_func0

Control-and-activation helper for layer 1 of the fixed-point XOR neural network. It holds two independent units. The **counter** unit counts per-input MAC completion pulses and raises a sticky done flag once every input of the neuron has been accumulated. The **func0** unit is the combinational sigmoid activation applied to the neuron's biased sum. The parent layer gates its MAC request with the done flag, uses the flag to start the bias add, and drives the add result through func0.

## Interface
Parameters
- N_INPUTS, default 2: number of MAC pulses that complete one neuron evaluation.
- DW, default 8: data width of z_value and a; signed Q4.4 format, where 16 represents 1.0.

Ports
- clk  in  1  clock; clock clk.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- ack  in  1  counter: one-cycle pulse, one per completed multiply-accumulate.
- ack_mac  out  1  counter: registered, sticky "all inputs accumulated" flag.
- z_value  in  DW signed  func0: pre-activation value, Q4.4.
- a  out  DW signed  func0: sigmoid output, Q4.4, combinational.

## Operation
Counter
- Internal count register, width clog2(N_INPUTS+1), saturating at N_INPUTS.
- Each rising edge of clk:
  - rst=1: count<=0, ack_mac<=0; rst has priority over ack.
  - else if ack=1 and count<N_INPUTS: count<=count+1; ack_mac<=1 when count+1==N_INPUTS.
  - else: hold.
- ack_mac stays 1 until rst; further ack pulses are ignored and the count does not wrap.
- ack held high for several cycles counts once per cycle.

func0 (sigmoid)
- Purely combinational; no clock or reset dependence.
- a = round(16 / (1 + exp(-z/16))), where z is the signed integer value of z_value in -128..127; round half up.
- Output range 0..16.
- Monotonic non-decreasing in z_value.
- Implemented as a 256-entry constant lookup indexed by z_value.
- Anchor values (z -> a):
  - -128 -> 0
  - -16 -> 4
  - -13 -> 5
  - 0 -> 8
  - 16 -> 12
  - 32 -> 14
  - 127 -> 16
- Every z <= -72 gives 0; every z >= 72 gives 16.

## Timing
- Reset values: count=0, ack_mac=0.
- ack_mac rises on the clk edge that samples the N_INPUTS-th ack=1, so it is visible in the next cycle.
- ack and rst in the same cycle: reset wins; count=0.
- rst asserted mid-evaluation (e.g. count=1): cleared next edge; the next evaluation needs N_INPUTS fresh ack pulses.
- func0 has zero latency: a settles in the same cycle z_value changes. The parent registers z_value and registers a.
- No X on outputs after the first reset edge; a is defined for all 256 inputs.

## Test plan
- Reset: rst=1 for 2 cycles with ack toggling -> ack_mac=0 throughout; after release, ack_mac=0 until pulses arrive.
- Count: release rst, pulse ack at cycles 3 and 6 -> ack_mac=0 through cycle 6, 1 from cycle 7 onward; extra pulses at 9 and 10 leave it at 1.
- Mid-operation reset: one ack pulse, then rst for one cycle, then one ack pulse -> ack_mac stays 0; a second post-reset pulse -> ack_mac=1.
- Simultaneous events: with count=1, assert ack and rst in the same cycle -> ack_mac=0 and count=0.
- Continuous ack: hold ack=1 for 2 cycles -> ack_mac=1 after the second edge.
- func0 sweep: drive z_value -128..127.
  - Check a at the anchors: -128->0, -13->5, 0->8, 16->12, 127->16.
  - Check monotonicity and the 0..16 range over the whole sweep.
  - Check that every value matches the rounding formula.
